rf_wb_scheduler: RTL
====================

Name: rf_wb_scheduler

Overview:
- Sequences all traffic into the register file's single write port and tracks pending destination registers for the issue stage.
- Arbitrates N_REQ write-back requesters (ALU, load unit, CSR unit) round-robin and drives the register file's write port from registers.
- Keeps a 32-bit busy scoreboard and raises a stall for RAW/WAW hazards.
- Sits between the execute/memory units and the register file, next to the issue stage.

Parameters:
- N_REQ, 3, number of write-back requesters; legal range 2..8.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous, active-low reset
- req_valid  input  N_REQ  requester i presents a write-back
- req_ready  output  N_REQ  requester i granted this cycle (one-hot or zero)
- req_rd_addr  input  N_REQ x reg_addr_t  destination per requester
- req_rd_data  input  N_REQ x word_t  write data per requester
- rf_write_en  output  1  register file write enable
- rf_rd_addr  output  reg_addr_t  register file destination
- rf_rd_data  output  word_t  register file write data
- iss_valid  input  1  issue stage holds an instruction
- iss_rs1_addr, iss_rs2_addr, iss_rd_addr  input  reg_addr_t each  operand/destination indices
- iss_uses_rs1, iss_uses_rs2, iss_writes_rd  input  1 each  operand/destination usage flags
- iss_stall  output  1  issue must hold this cycle
- busy_mask  output  32  scoreboard contents, for debug/assertions

Behaviour:
- Reset (rst==0 at posedge):
  - rf_write_en=0, rf_rd_addr=0, rf_rd_data=0
  - busy_mask=0, rr pointer=0
  - req_ready forced to 0 while rst==0; requests seen during reset are not granted.
- Arbitration:
  - Combinational. Round-robin starting at index ptr; the first i with req_valid[i] wins; req_ready[i]=1 for the winner only.
  - Handshake completes on req_valid&req_ready. A requester holds valid/addr/data stable until ready.
  - ptr <= winner+1, mod N_REQ, on each grant; unchanged when no request.
- Write port:
  - Registered, so grant to rf_write_en latency is 1 cycle. Data lands in the register file at the following edge, 2 edges after grant.
  - At the grant edge: rf_rd_addr<=winner addr, rf_rd_data<=winner data, rf_write_en<=(addr!=0).
  - No grant: rf_write_en<=0; rf_rd_addr/rf_rd_data hold their last values.
- Scoreboard:
  - Bit r sets at an edge where iss_valid & !iss_stall & iss_writes_rd & iss_rd_addr==r & r!=0.
  - Bit r clears at an edge where rf_write_en & rf_rd_addr==r, i.e. the same edge the register file latches the data.
  - Set and clear of the same r in one cycle: set wins.
  - busy_mask[0] is always 0.
- Stall (combinational):
  - iss_stall = iss_valid & ((uses_rs1 & busy[rs1]) | (uses_rs2 & busy[rs2]) | (writes_rd & busy[rd])).
  - There is no bypass, so a register becomes readable the cycle after its bit clears.
- Write-backs with no matching busy bit are still written; the scoreboard is unaffected.
- x0: a granted write to rd=0 consumes the grant and advances ptr, but rf_write_en stays 0.
- Reset mid-operation: a granted-but-unwritten entry is dropped and all pending busy bits are lost. The core reset flushes the requesters.

Decomposition:
- Package (types.sv):
  - reg_addr_t and word_t (existing)
  - NUM_REGS=32
  - wb_req_t struct {reg_addr_t rd_addr; word_t rd_data;}
  - N_WB_REQ default constant
- Sub-module rr_arbiter (N parameter):
  - inputs req vector and ptr; outputs one-hot grant and winner index.
  - Pure combinational; the ptr register stays in rf_wb_scheduler.

Test Plan:
- Reset, then req_valid=3'b111 held with rd=5/6/7 → grants in order 0,1,2,0; rf_write_en high one cycle after each grant, with matching addr/data.
- Issue writes_rd rd=8, then rs1=8 read while requester 1 is idle → iss_stall=1; requester 1 writes rd=8 data 0xDEADBEEF → busy_mask[8] clears at the write edge and stall drops the next cycle.
- Requester 2 writes rd=0 data 0x1234 → req_ready[2]=1, rf_write_en stays 0, ptr advances to 0.
- Same cycle: issue reserves rd=9 while rf_write_en writes rd=9 → busy_mask[9] remains 1.
- Issue rd=3 while busy[3]=1 (WAW) → iss_stall=1, no new set. Same issue with writes_rd=0 and rs regs free → no stall.
- rst=0 asserted with busy_mask=0x0000_0110 and req_valid=1 → next edge: busy_mask=0, rf_write_en=0, req_ready=0 throughout reset.

Source files
------------

// File: rtl/rf_wb_scheduler_pkg.sv
// Shared types for the register-file write-back scheduler: register index,
// data word and the write-back request record.
package rf_wb_scheduler_pkg;

  localparam int NUM_REGS = 32;
  localparam int N_WB_REQ = 3;

  typedef logic [$clog2(NUM_REGS)-1:0] reg_addr_t;
  typedef logic [31:0]                 word_t;

  typedef struct packed {
    reg_addr_t rd_addr;
    word_t     rd_data;
  } wb_req_t;

endpackage

// File: rtl/rf_wb_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr
// (wrapping) wins. The pointer register lives in the caller.
module rr_arbiter #(
  parameter int N = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] winner,
  output logic          any
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  // NOTE: every output and temporary gets a default first so no path infers a latch.
  always_comb begin
    grant  = '0;
    winner = '0;
    any    = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      idx = sum[PW-1:0];
      if (!any && req[idx]) begin
        grant[idx] = 1'b1;
        winner     = idx;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Register-file write-port sequencer: round-robin write-back arbitration,
// registered write port and a busy scoreboard that stalls RAW/WAW hazards.
module rf_wb_scheduler
  import rf_wb_scheduler_pkg::*;
#(
  parameter int N_REQ = N_WB_REQ
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  reg_addr_t [N_REQ-1:0] req_rd_addr,
  input  word_t [N_REQ-1:0]     req_rd_data,
  output logic                  rf_write_en,
  output reg_addr_t             rf_rd_addr,
  output word_t                 rf_rd_data,
  input  logic                  iss_valid,
  input  reg_addr_t             iss_rs1_addr,
  input  reg_addr_t             iss_rs2_addr,
  input  reg_addr_t             iss_rd_addr,
  input  logic                  iss_uses_rs1,
  input  logic                  iss_uses_rs2,
  input  logic                  iss_writes_rd,
  output logic                  iss_stall,
  output logic [NUM_REGS-1:0]   busy_mask
);

  localparam int PW = $clog2(N_REQ);

  logic [PW-1:0]       ptr_q, ptr_d;
  logic                we_q, we_d;
  reg_addr_t           addr_q, addr_d;
  word_t               data_q, data_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;

  logic [N_REQ-1:0] grant;
  logic [PW-1:0]    winner;
  logic             any_grant;
  wb_req_t          win_req;

  // Requests are masked during reset so nothing is granted until it releases.
  rr_arbiter #(.N(N_REQ)) u_arb (
    .req    (req_valid & {N_REQ{rst}}),
    .ptr    (ptr_q),
    .grant  (grant),
    .winner (winner),
    .any    (any_grant)
  );

  assign req_ready   = grant;
  assign win_req     = '{rd_addr: req_rd_addr[winner], rd_data: req_rd_data[winner]};
  assign rf_write_en = we_q;
  assign rf_rd_addr  = addr_q;
  assign rf_rd_data  = data_q;
  assign busy_mask   = busy_q;

  assign iss_stall = iss_valid & ((iss_uses_rs1  & busy_q[iss_rs1_addr]) |
                                  (iss_uses_rs2  & busy_q[iss_rs2_addr]) |
                                  (iss_writes_rd & busy_q[iss_rd_addr]));

  always_comb begin
    ptr_d  = ptr_q;
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (any_grant) begin
      ptr_d  = (winner == PW'(N_REQ-1)) ? '0 : winner + PW'(1);
      addr_d = win_req.rd_addr;
      data_d = win_req.rd_data;
      we_d   = (win_req.rd_addr != '0);
    end

    // Clear first, then set, so a same-cycle reservation of the register wins.
    busy_d = busy_q;
    if (we_q) busy_d[addr_q] = 1'b0;
    if (iss_valid && !iss_stall && iss_writes_rd) busy_d[iss_rd_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q  <= '0;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      busy_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end

endmodule
